// File: rtl/regfile_read_ctrl_pkg.sv
// Shared constants for the register-file read side: scan FSM encodings and default sizes.
// Build option RF_BYPASS_EN selects write-through for same-edge read/write of one register.
package regfile_read_ctrl_pkg;

    localparam int RF_N_DEFAULT = 2;
    localparam int RF_W_DEFAULT = 16;

    localparam logic [1:0] SCAN_IDLE = 2'd0;
    localparam logic [1:0] SCAN_RUN  = 2'd1;
    localparam logic [1:0] SCAN_DONE = 2'd2;

`ifdef RF_BYPASS_EN
    localparam logic RF_BYPASS = 1'b1;
`else
    localparam logic RF_BYPASS = 1'b0;
`endif

endpackage

// File: rtl/regfile_read_ctrl_rf_read_port.sv
// One registered read port: address/enable in, data/valid out one cycle later.
// Honours RF_BYPASS_EN (via the package) for a read that collides with a legal write.
module rf_read_port
    import regfile_read_ctrl_pkg::*;
#(
    parameter  int N = RF_N_DEFAULT,
    parameter  int W = RF_W_DEFAULT,
    localparam int M = 2**N
)(
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_rd_en,
    input  logic [N-1:0]          i_rd_addr,
    input  logic [M-1:0][W-1:0]   i_regs,
    input  logic [M-1:0]          i_wr_en,
    input  logic [W-1:0]          i_wr_data,
    input  logic                  i_wr_ok,
    output logic [W-1:0]          o_rd_data,
    output logic                  o_rd_valid
);

    logic         w_hit;
    logic [W-1:0] w_data;

    // A rejected multi-hot write is never forwarded.
    assign w_hit  = RF_BYPASS && i_wr_ok && i_wr_en[i_rd_addr];
    assign w_data = w_hit ? i_wr_data : i_regs[i_rd_addr];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rd_data  <= '0;
            o_rd_valid <= 1'b0;
        end else begin
            o_rd_valid <= i_rd_en;
            if (i_rd_en) begin
                o_rd_data <= w_data;
            end
        end
    end

endmodule

// File: rtl/regfile_read_ctrl.sv
// Register file storage, one-hot write, two read ports and a valid/ready scan dump engine.
// Define RF_BYPASS_EN for write-through on same-edge read/write (ports and scan loads).
module regfile_read_ctrl
    import regfile_read_ctrl_pkg::*;
#(
    parameter  int N = RF_N_DEFAULT,
    parameter  int W = RF_W_DEFAULT,
    localparam int M = 2**N
)(
    input  logic          Clk,
    input  logic          ResetN,
    input  logic [M-1:0]  WrEn,
    input  logic [W-1:0]  WrData,
    input  logic          RdEnA,
    input  logic          RdEnB,
    input  logic [N-1:0]  RdAddrA,
    input  logic [N-1:0]  RdAddrB,
    output logic [W-1:0]  RdDataA,
    output logic [W-1:0]  RdDataB,
    output logic          RdValidA,
    output logic          RdValidB,
    output logic          WrErr,
    input  logic          ScanStart,
    input  logic          ScanReady,
    output logic          ScanValid,
    output logic [N-1:0]  ScanAddr,
    output logic [W-1:0]  ScanData,
    output logic          ScanBusy,
    output logic          ScanDone
);

    logic [M-1:0][W-1:0] r_regs;
    logic                r_wr_err;
    logic [1:0]          r_state;
    logic [N-1:0]        r_scan_addr;
    logic [W-1:0]        r_scan_data;
    logic                r_scan_valid;
    logic                r_scan_done;

    logic                w_wr_ok;
    logic                w_wr_multi;
    logic                w_scan_accept;
    logic                w_scan_last;
    logic [N-1:0]        w_load_addr;
    logic [W-1:0]        w_load_data;

    assign w_wr_ok    = $onehot(WrEn);
    assign w_wr_multi = (|WrEn) && !w_wr_ok;

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            r_regs   <= '0;
            r_wr_err <= 1'b0;
        end else begin
            if (w_wr_multi) begin
                r_wr_err <= 1'b1;
            end
            for (int i = 0; i < M; i++) begin
                if (w_wr_ok && WrEn[i]) begin
                    r_regs[i] <= WrData;
                end
            end
        end
    end

    rf_read_port #(.N(N), .W(W)) u_port_a (
        .i_clk      (Clk),
        .i_rst_n    (ResetN),
        .i_rd_en    (RdEnA),
        .i_rd_addr  (RdAddrA),
        .i_regs     (r_regs),
        .i_wr_en    (WrEn),
        .i_wr_data  (WrData),
        .i_wr_ok    (w_wr_ok),
        .o_rd_data  (RdDataA),
        .o_rd_valid (RdValidA)
    );

    rf_read_port #(.N(N), .W(W)) u_port_b (
        .i_clk      (Clk),
        .i_rst_n    (ResetN),
        .i_rd_en    (RdEnB),
        .i_rd_addr  (RdAddrB),
        .i_regs     (r_regs),
        .i_wr_en    (WrEn),
        .i_wr_data  (WrData),
        .i_wr_ok    (w_wr_ok),
        .o_rd_data  (RdDataB),
        .o_rd_valid (RdValidB)
    );

    // Beats are snapshots taken at load time; the held beat ignores later writes.
    assign w_scan_accept = r_scan_valid && ScanReady;
    assign w_scan_last   = (r_scan_addr == N'(M-1));
    assign w_load_addr   = (r_state == SCAN_RUN) ? r_scan_addr + N'(1) : '0;
    assign w_load_data   = (RF_BYPASS && w_wr_ok && WrEn[w_load_addr]) ? WrData
                                                                       : r_regs[w_load_addr];

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            r_state      <= SCAN_IDLE;
            r_scan_addr  <= '0;
            r_scan_data  <= '0;
            r_scan_valid <= 1'b0;
            r_scan_done  <= 1'b0;
        end else begin
            r_scan_done <= 1'b0;
            case (r_state)
                SCAN_IDLE: begin
                    if (ScanStart) begin
                        r_state      <= SCAN_RUN;
                        r_scan_addr  <= '0;
                        r_scan_data  <= w_load_data;
                        r_scan_valid <= 1'b1;
                    end
                end
                SCAN_RUN: begin
                    if (w_scan_accept) begin
                        if (w_scan_last) begin
                            r_state      <= SCAN_DONE;
                            r_scan_valid <= 1'b0;
                            r_scan_done  <= 1'b1;
                        end else begin
                            r_scan_addr <= w_load_addr;
                            r_scan_data <= w_load_data;
                        end
                    end
                end
                SCAN_DONE: r_state <= SCAN_IDLE;
                default:   r_state <= SCAN_IDLE;
            endcase
        end
    end

    assign WrErr     = r_wr_err;
    assign ScanValid = r_scan_valid;
    assign ScanAddr  = r_scan_addr;
    assign ScanData  = r_scan_data;
    assign ScanBusy  = (r_state == SCAN_RUN);
    assign ScanDone  = r_scan_done;

endmodule
